// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared constants and helpers for the DataMover command sequencer
package accel_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_ADDR    = 3'd2;
    localparam logic [2:0] REG_LEN     = 3'd3;
    localparam logic [2:0] REG_DONE    = 3'd4;
    localparam logic [2:0] REG_STS_POP = 3'd5;
    localparam logic [2:0] REG_IRQ_MSK = 3'd6;

    localparam int CMD_BTT_LSB   = 0;
    localparam int CMD_BTT_W     = 23;
    localparam int CMD_INCR_BIT  = 23;
    localparam int CMD_DSA_LSB   = 24;
    localparam int CMD_EOF_BIT   = 30;
    localparam int CMD_DRR_BIT   = 31;
    localparam int CMD_SADDR_LSB = 32;
    localparam int CMD_TAG_LSB   = 64;

    localparam int STAT_DESC_CNT_LSB = 0;
    localparam int STAT_OUTST_LSB    = 4;
    localparam int STAT_STS_CNT_LSB  = 8;
    localparam int STAT_DESC_FULL    = 16;
    localparam int STAT_STS_EMPTY    = 17;
    localparam int STAT_ERROR        = 18;
    localparam int STAT_OVERFLOW     = 19;

    typedef enum logic {SEQ_IDLE, SEQ_ISSUE} seq_state_t;

    function automatic logic [71:0] make_cmd(input logic [31:0] saddr,
                                             input logic [22:0] btt,
                                             input logic [3:0]  tag);
        logic [71:0] c;
        c = '0;
        c[CMD_BTT_LSB +: CMD_BTT_W] = btt;
        c[CMD_INCR_BIT]             = 1'b1;
        c[CMD_DSA_LSB +: 6]         = 6'h0;
        c[CMD_EOF_BIT]              = 1'b1;
        c[CMD_DRR_BIT]              = 1'b0;
        c[CMD_SADDR_LSB +: 32]      = saddr;
        c[CMD_TAG_LSB +: 4]         = tag;
        return c;
    endfunction

    // A good completion has OKAY bit 7 set and no slave/decode/internal error bits.
    function automatic logic sts_is_error(input logic [7:0] s);
        return (s[6:4] != 3'b000) || !s[7];
    endfunction

endpackage

// File: rtl/accel_dma_sequencer_if.sv
// rtl/accel_dma_sequencer_if.sv - DataMover command and status streams
interface accel_dma_sequencer_if;
    logic [71:0] cmd_tdata;
    logic        cmd_tvalid;
    logic        cmd_tready;
    logic [7:0]  sts_tdata;
    logic        sts_tvalid;
    logic        sts_tready;

    modport master (output cmd_tdata, cmd_tvalid, input cmd_tready,
                    input sts_tdata, sts_tvalid, output sts_tready);
    modport slave  (input cmd_tdata, cmd_tvalid, output cmd_tready,
                    output sts_tdata, sts_tvalid, input sts_tready);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with synchronous clear and occupancy count
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = count[DEPTH_LOG2];
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/accel_dma_sequencer.sv
// rtl/accel_dma_sequencer.sv - register-programmed DataMover command sequencer; ACCEL_SEQ_IRQ_EN adds irq and IRQ_MSK
module accel_dma_sequencer
    import accel_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_DESC_DEPTH_LOG2  = 3,
    parameter int C_MAX_OUTSTANDING  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] set_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] set_data,
    input  logic                          set_stb,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] get_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] get_data,
    input  logic                          get_stb,
    accel_dma_sequencer_if.master         dm
`ifdef ACCEL_SEQ_IRQ_EN
    ,
    output logic                          irq
`endif
);
    localparam int CNT_W  = C_DESC_DEPTH_LOG2 + 1;
    localparam int DESC_W = 32 + 23;

    logic [2:0]        set_off, get_off;
    logic              wr_ctrl, wr_addr, wr_len, rd_pop, soft_clr;
    logic              enable, error_flag, overflow, irq_msk, cmd_stale;
    logic [31:0]       addr_stage, done_cnt;
    logic [3:0]        outstanding, tag;
    seq_state_t        state;
    logic              cmd_hs, sts_hs;
    logic [DESC_W-1:0] desc_head;
    logic [CNT_W-1:0]  desc_count, sts_count;
    logic              desc_full, desc_empty, sts_full, sts_empty;
    logic [7:0]        sts_head;
    logic              unused_addr_bits;

    assign set_off  = set_addr[4:2];
    assign get_off  = get_addr[4:2];
    assign wr_ctrl  = set_stb && (set_off == REG_CTRL);
    assign wr_addr  = set_stb && (set_off == REG_ADDR);
    assign wr_len   = set_stb && (set_off == REG_LEN);
    assign rd_pop   = get_stb && (get_off == REG_STS_POP);
    assign soft_clr = wr_ctrl && set_data[1];
    assign unused_addr_bits = ^{set_addr[C_S_AXI_ADDR_WIDTH-1:5], set_addr[1:0],
                                get_addr[C_S_AXI_ADDR_WIDTH-1:5], get_addr[1:0]};

    assign cmd_hs        = dm.cmd_tvalid && dm.cmd_tready;
    assign sts_hs        = dm.sts_tvalid && dm.sts_tready;
    assign dm.sts_tready = !rst && !sts_full;

    // An in-flight command whose descriptor was soft-cleared must not pop a newer entry.
    sync_fifo #(.WIDTH(DESC_W), .DEPTH_LOG2(C_DESC_DEPTH_LOG2)) u_desc_fifo (
        .clk(clk), .rst(rst), .clr(soft_clr),
        .push(wr_len), .push_data({addr_stage, set_data[22:0]}),
        .pop(cmd_hs && !cmd_stale), .head(desc_head),
        .count(desc_count), .full(desc_full), .empty(desc_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(C_DESC_DEPTH_LOG2)) u_sts_fifo (
        .clk(clk), .rst(rst), .clr(soft_clr),
        .push(sts_hs), .push_data(dm.sts_tdata),
        .pop(rd_pop), .head(sts_head),
        .count(sts_count), .full(sts_full), .empty(sts_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SEQ_IDLE;
            dm.cmd_tvalid <= 1'b0;
            dm.cmd_tdata  <= '0;
            cmd_stale     <= 1'b0;
            tag           <= '0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (enable && !desc_empty && !soft_clr &&
                        (outstanding < 4'(C_MAX_OUTSTANDING))) begin
                        dm.cmd_tdata  <= make_cmd(desc_head[DESC_W-1:23], desc_head[22:0], tag);
                        dm.cmd_tvalid <= 1'b1;
                        cmd_stale     <= 1'b0;
                        state         <= SEQ_ISSUE;
                    end
                end
                SEQ_ISSUE: begin
                    if (soft_clr) cmd_stale <= 1'b1;
                    if (dm.cmd_tready) begin
                        dm.cmd_tvalid <= 1'b0;
                        tag           <= tag + 1'b1;
                        state         <= SEQ_IDLE;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable      <= 1'b0;
            addr_stage  <= '0;
            done_cnt    <= '0;
            error_flag  <= 1'b0;
            overflow    <= 1'b0;
            outstanding <= '0;
        end else begin
            if (wr_ctrl) enable     <= set_data[0];
            if (wr_addr) addr_stage <= set_data[31:0];
            case ({cmd_hs, sts_hs})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
                default: ;
            endcase
            if (soft_clr) begin
                done_cnt   <= '0;
                error_flag <= 1'b0;
                overflow   <= 1'b0;
            end else begin
                if (sts_hs) begin
                    done_cnt <= done_cnt + 1'b1;
                    if (sts_is_error(dm.sts_tdata) || (outstanding == '0 && !cmd_hs))
                        error_flag <= 1'b1;
                end
                if (wr_len && desc_full) overflow <= 1'b1;
            end
        end
    end

`ifdef ACCEL_SEQ_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         irq_msk <= 1'b0;
        else if (set_stb && (set_off == REG_IRQ_MSK))    irq_msk <= set_data[0];
    end
    assign irq = irq_msk && !sts_empty;
`else
    assign irq_msk = 1'b0;
`endif

    always_comb begin
        get_data = '0;
        case (get_off)
            REG_CTRL:    get_data[0] = enable;
            REG_STATUS: begin
                get_data[STAT_DESC_CNT_LSB +: 4] = 4'(desc_count);
                get_data[STAT_OUTST_LSB +: 4]    = outstanding;
                get_data[STAT_STS_CNT_LSB +: 4]  = 4'(sts_count);
                get_data[STAT_DESC_FULL]         = desc_full;
                get_data[STAT_STS_EMPTY]         = sts_empty;
                get_data[STAT_ERROR]             = error_flag;
                get_data[STAT_OVERFLOW]          = overflow;
            end
            REG_ADDR:    get_data[31:0] = addr_stage;
            REG_DONE:    get_data[31:0] = done_cnt;
            REG_STS_POP: if (!sts_empty) get_data[7:0] = sts_head;
            REG_IRQ_MSK: get_data[0] = irq_msk;
            default:     ;
        endcase
    end
endmodule

// File: tb/tb_accel_dma_sequencer.sv
// tb/tb_accel_dma_sequencer.sv - randomized self-checking bench for accel_dma_sequencer
module tb_accel_dma_sequencer;
    localparam logic [2:0] O_CTRL = 3'd0, O_STATUS = 3'd1, O_ADDR = 3'd2, O_LEN = 3'd3;
    localparam logic [2:0] O_DONE = 3'd4, O_POP = 3'd5, O_IRQ = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] set_addr, set_data, get_addr, get_data;
    logic        set_stb, get_stb;
    int          checks = 0;
    int          fails = 0;
    logic [71:0] got_q[$];

    accel_dma_sequencer_if dm();
`ifdef ACCEL_SEQ_IRQ_EN
    logic irq;
`endif

    accel_dma_sequencer #(
        .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32),
        .C_DESC_DEPTH_LOG2(3), .C_MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst(rst),
        .set_addr(set_addr), .set_data(set_data), .set_stb(set_stb),
        .get_addr(get_addr), .get_data(get_data), .get_stb(get_stb),
        .dm(dm)
`ifdef ACCEL_SEQ_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && dm.cmd_tvalid && dm.cmd_tready) got_q.push_back(dm.cmd_tdata);
    end

    function automatic logic [71:0] exp_cmd(input logic [31:0] a, input logic [22:0] l,
                                            input logic [3:0] t);
        return {4'h0, t, a, 1'b0, 1'b1, 6'h00, 1'b1, l};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [2:0] off, input logic [31:0] d);
        set_addr = {27'b0, off, 2'b00};
        set_data = d;
        set_stb  = 1'b1;
        tick();
        set_stb  = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] off, input logic pop, output logic [31:0] d);
        get_addr = {27'b0, off, 2'b00};
        get_stb  = pop;
        #1;
        d = get_data;
        tick();
        get_stb  = 1'b0;
    endtask

    task automatic push_desc(input logic [31:0] a, input logic [22:0] l);
        reg_write(O_ADDR, a);
        reg_write(O_LEN, {9'h0, l});
    endtask

    task automatic idle_inputs();
        set_stb = 0; get_stb = 0; set_addr = 0; set_data = 0; get_addr = 0;
        dm.cmd_tready = 0; dm.sts_tvalid = 0; dm.sts_tdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        got_q.delete();
        tick();
    endtask

    task automatic send_sts(input logic [7:0] s);
        int n = 0;
        dm.sts_tdata  = s;
        dm.sts_tvalid = 1'b1;
        while (!dm.sts_tready && n < 50) begin tick(); n++; end
        tick();
        dm.sts_tvalid = 1'b0;
        checks++;
        if (n >= 50) begin fails++; $display("FAIL send_sts_timeout: tready stayed 0, required 1"); end
    endtask

    task automatic wait_tvalid(input string name);
        int n = 0;
        while (dm.cmd_tvalid !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (dm.cmd_tvalid !== 1'b1) begin fails++; $display("FAIL %s_tvalid_timeout: got 0 required 1", name); end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dm.sts_tready !== 1'b0) begin fails++; $display("FAIL reset_sts_tready_during: got %b required 0", dm.sts_tready); end
        checks++; if (dm.cmd_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b required 0", dm.cmd_tvalid); end
        rst = 1'b0;
        tick();
        checks++; if (dm.cmd_tdata !== 72'h0) begin fails++; $display("FAIL reset_tdata: got %h required 0", dm.cmd_tdata); end
        checks++; if (dm.sts_tready !== 1'b1) begin fails++; $display("FAIL reset_sts_tready_after: got %b required 1", dm.sts_tready); end
        reg_read(O_STATUS, 1'b0, d);
        checks++; if (d !== 32'h0002_0000) begin fails++; $display("FAIL reset_status: got %h required 00020000", d); end
        reg_read(O_CTRL, 1'b0, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h required 0", d); end
        reg_read(O_DONE, 1'b0, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_done: got %h required 0", d); end
        reg_read(O_POP, 1'b1, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_pop: got %h required 0", d); end
        reg_write(O_IRQ, 32'h1);
        reg_read(O_IRQ, 1'b0, d);
`ifdef ACCEL_SEQ_IRQ_EN
        checks++; if (d !== 32'h1) begin fails++; $display("FAIL irq_msk_rw: got %h required 1", d); end
`else
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL irq_msk_absent: got %h required 0", d); end
`endif
    endtask

    task automatic test_single_cmd();
        logic [31:0] d;
        logic [71:0] want;
        want = {4'h0, 4'h0, 32'h1000_0000, 8'h40, 1'b1, 23'h40};
        do_reset();
        dm.cmd_tready = 1'b1;
        reg_write(O_CTRL, 32'h1);
        reg_write(O_ADDR, 32'h1000_0000);
        reg_write(O_LEN, 32'h40);
        checks++; if (dm.cmd_tvalid !== 1'b0) begin fails++; $display("FAIL single_latency_early: got %b required 0", dm.cmd_tvalid); end
        tick();
        checks++; if (dm.cmd_tvalid !== 1'b1) begin fails++; $display("FAIL single_latency_n2: got %b required 1", dm.cmd_tvalid); end
        checks++; if (dm.cmd_tdata !== want) begin fails++; $display("FAIL single_tdata: got %h required %h", dm.cmd_tdata, want); end
        repeat (3) tick();
        checks++; if (got_q.size() != 1) begin fails++; $display("FAIL single_count: got %0d required 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== want) begin fails++; $display("FAIL single_hs_tdata: got %h required %h", got_q[0], want); end
        end
        reg_read(O_STATUS, 1'b0, d);
        checks++; if (d !== 32'h0002_0010) begin fails++; $display("FAIL single_status: got %h required 00020010", d); end
    endtask

    task automatic test_outstanding_limit();
        logic [31:0] d;
        do_reset();
        dm.cmd_tready = 1'b1;
        reg_write(O_CTRL, 32'h1);
        for (int i = 0; i < 6; i++) push_desc(32'h2000_0000 + 32'(i) * 32'h100, 23'h10 + 23'(i));
        repeat (20) tick();
        checks++; if (got_q.size() != 4) begin fails++; $display("FAIL limit_count4: got %0d required 4", got_q.size()); end
        checks++; if (dm.cmd_tvalid !== 1'b0) begin fails++; $display("FAIL limit_tvalid_held: got %b required 0", dm.cmd_tvalid); end
        reg_read(O_STATUS, 1'b0, d);
        checks++; if (d[7:0] !== 8'h42) begin fails++; $display("FAIL limit_status: got %h required outst 4 desc 2", d[7:0]); end
        send_sts(8'h80);
        repeat (10) tick();
        checks++; if (got_q.size() != 5) begin fails++; $display("FAIL limit_count5: got %0d required 5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_cmd(32'h2000_0000 + 32'(i) * 32'h100, 23'h10 + 23'(i), 4'(i))) begin
                fails++; $display("FAIL limit_cmd%0d: got %h required %h", i, got_q[i],
                    exp_cmd(32'h2000_0000 + 32'(i) * 32'h100, 23'h10 + 23'(i), 4'(i)));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [71:0] held;
        do_reset();
        reg_write(O_CTRL, 32'h1);
        push_desc(32'h3000_0000, 23'h123);
        wait_tvalid("bp");
        held = dm.cmd_tdata;
        checks++; if (held !== exp_cmd(32'h3000_0000, 23'h123, 4'h0)) begin fails++; $display("FAIL bp_tdata: got %h required %h", held, exp_cmd(32'h3000_0000, 23'h123, 4'h0)); end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) reg_write(O_CTRL, 32'h0);
            else tick();
            checks++;
            if ({dm.cmd_tvalid, dm.cmd_tdata} !== {1'b1, held}) begin
                fails++; $display("FAIL bp_hold%0d: got %b/%h required 1/%h", i, dm.cmd_tvalid, dm.cmd_tdata, held);
            end
        end
        dm.cmd_tready = 1'b1;
        tick();
        dm.cmd_tready = 1'b0;
        repeat (5) tick();
        checks++; if (got_q.size() != 1) begin fails++; $display("FAIL bp_single_hs: got %0d required 1", got_q.size()); end
        checks++; if (dm.cmd_tvalid !== 1'b0) begin fails++; $display("FAIL bp_release: got %b required 0", dm.cmd_tvalid); end
        reg_read(O_STATUS, 1'b0, d);
        checks++; if (d[7:4] !== 4'd1) begin fails++; $display("FAIL bp_outstanding: got %0d required 1", d[7:4]); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int returned = 0;
        do_reset();
        for (int i = 0; i < 9; i++) push_desc(32'h4000_0000 + 32'(i) * 32'h1000, 23'(i + 1));
        reg_read(O_STATUS, 1'b0, d);
        checks++; if (d[16] !== 1'b1) begin fails++; $display("FAIL ovf_full: got %b required 1", d[16]); end
        checks++; if (d[19] !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b required 1", d[19]); end
        checks++; if (d[3:0] !== 4'd8) begin fails++; $display("FAIL ovf_count: got %0d required 8", d[3:0]); end
        dm.cmd_tready = 1'b1;
        reg_write(O_CTRL, 32'h1);
        for (int c = 0; c < 300; c++) begin
            if (returned < got_q.size() && dm.sts_tready) begin
                dm.sts_tvalid = 1'b1; dm.sts_tdata = 8'h80; returned++;
            end else dm.sts_tvalid = 1'b0;
            tick();
        end
        dm.sts_tvalid = 1'b0;
        checks++; if (got_q.size() != 8) begin fails++; $display("FAIL ovf_issued: got %0d required 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_cmd(32'h4000_0000 + 32'(i) * 32'h1000, 23'(i + 1), 4'(i))) begin
                fails++; $display("FAIL ovf_cmd%0d: got %h required %h", i, got_q[i],
                    exp_cmd(32'h4000_0000 + 32'(i) * 32'h1000, 23'(i + 1), 4'(i)));
            end
        end
        reg_read(O_STATUS, 1'b0, d);
        checks++; if (d !== 32'h0008_0800) begin fails++; $display("FAIL ovf_final_status: got %h required 00080800", d); end
    endtask

    task automatic test_status_pop();
        logic [31:0] d;
        do_reset();
        dm.cmd_tready = 1'b1;
        reg_write(O_CTRL, 32'h1);
        push_desc(32'h5000_0000, 23'h8);
        push_desc(32'h5000_1000, 23'h8);
        repeat (6) tick();
        checks++; if (got_q.size() != 2) begin fails++; $display("FAIL pop_issued: got %0d required 2", got_q.size()); end
        send_sts(8'h80);
        reg_read(O_STATUS, 1'b0, d);
        checks++; if (d[18] !== 1'b0) begin fails++; $display("FAIL pop_err_after_80: got %b required 0", d[18]); end
        send_sts(8'hC1);
        reg_read(O_STATUS, 1'b0, d);
        checks++; if (d[19:4] !== 16'h4020) begin fails++; $display("FAIL pop_status_after_c1: got %h required 4020", d[19:4]); end
        reg_read(O_DONE, 1'b0, d);
        checks++; if (d !== 32'd2) begin fails++; $display("FAIL pop_done: got %0d required 2", d); end
        reg_read(O_POP, 1'b1, d);
        checks++; if (d !== 32'h80) begin fails++; $display("FAIL pop_first: got %h required 80", d); end
        reg_read(O_POP, 1'b1, d);
        checks++; if (d !== 32'hC1) begin fails++; $display("FAIL pop_second: got %h required c1", d); end
        reg_read(O_POP, 1'b1, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL pop_empty: got %h required 0", d); end
        reg_write(O_CTRL, 32'h3);
        reg_read(O_CTRL, 1'b0, d);
        checks++; if (d !== 32'h1) begin fails++; $display("FAIL clr_selfclear: got %h required 1", d); end
        reg_read(O_DONE, 1'b0, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL clr_done: got %h required 0", d); end
        send_sts(8'h80);
        reg_read(O_STATUS, 1'b0, d);
        checks++; if (d !== 32'h0004_0100) begin fails++; $display("FAIL spurious_status: got %h required 00040100", d); end
    endtask

    task automatic test_random();
        localparam int N = 40;
        logic [31:0] ra[$];
        logic [22:0] rl[$];
        logic [7:0]  sq[$];
        logic [31:0] cur_addr, rnd, d;
        logic [22:0] cur_len;
        logic [7:0]  s;
        logic        exp_err = 1'b0;
        logic        done = 1'b0;
        int pushed = 0, returned = 0, phase = 0;
        do_reset();
        reg_write(O_CTRL, 32'h1);
        for (int c = 0; c < 4000 && !done; c++) begin
            set_stb = 1'b0;
            get_stb = 1'b0;
            dm.cmd_tready = ($urandom_range(0, 3) != 0);
            if (phase == 1) begin
                rnd = $urandom;
                set_addr = {27'b0, O_LEN, 2'b00};
                set_data = {rnd[31:23], cur_len};
                set_stb = 1'b1;
                ra.push_back(cur_addr);
                rl.push_back(cur_len);
                pushed++;
                phase = 0;
            end else if (pushed < N && (pushed - got_q.size()) < 8 && $urandom_range(0, 1) == 1) begin
                cur_addr = $urandom;
                rnd = $urandom;
                cur_len = rnd[22:0];
                set_addr = {27'b0, O_ADDR, 2'b00};
                set_data = cur_addr;
                set_stb = 1'b1;
                phase = 1;
            end
            if (sq.size() > 0 && $urandom_range(0, 2) == 0) begin
                get_addr = {27'b0, O_POP, 2'b00};
                get_stb = 1'b1;
                #1;
                checks++;
                if (get_data !== {24'h0, sq[0]}) begin
                    fails++; $display("FAIL rand_pop: got %h required %h", get_data, sq[0]);
                end
                void'(sq.pop_front());
            end
            if (returned < got_q.size() && dm.sts_tready && $urandom_range(0, 1) == 1) begin
                rnd = $urandom;
                s = rnd[0] ? {4'b1000, rnd[11:8]} : rnd[15:8];
                dm.sts_tvalid = 1'b1;
                dm.sts_tdata = s;
                sq.push_back(s);
                returned++;
                if (s[7] == 1'b0 || s[6:4] != 3'b000) exp_err = 1'b1;
            end else dm.sts_tvalid = 1'b0;
            tick();
            done = (pushed == N) && (got_q.size() == N) && (returned == N) && (sq.size() == 0);
        end
        idle_inputs();
        checks++; if (!done) begin fails++; $display("FAIL rand_timeout: pushed %0d issued %0d returned %0d required %0d", pushed, got_q.size(), returned, N); end
        checks++; if (got_q.size() != N) begin fails++; $display("FAIL rand_issued: got %0d required %0d", got_q.size(), N); end
        for (int i = 0; i < N && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_cmd(ra[i], rl[i], 4'(i))) begin
                fails++; $display("FAIL rand_cmd%0d: got %h required %h", i, got_q[i], exp_cmd(ra[i], rl[i], 4'(i)));
            end
        end
        reg_read(O_DONE, 1'b0, d);
        checks++; if (d !== 32'(returned)) begin fails++; $display("FAIL rand_done: got %0d required %0d", d, returned); end
        reg_read(O_STATUS, 1'b0, d);
        checks++;
        if (d !== (32'h0002_0000 | {13'h0, exp_err, 18'h0})) begin
            fails++; $display("FAIL rand_status: got %h required %h", d, 32'h0002_0000 | {13'h0, exp_err, 18'h0});
        end
    endtask

    task automatic test_reset_mid_issue();
        logic [31:0] d;
        do_reset();
        reg_write(O_CTRL, 32'h1);
        push_desc(32'h6000_0000, 23'h55);
        wait_tvalid("rst_mid");
        #2 rst = 1'b1;
        #1;
        checks++; if (dm.cmd_tvalid !== 1'b0) begin fails++; $display("FAIL rst_mid_tvalid: got %b required 0", dm.cmd_tvalid); end
        checks++; if (dm.cmd_tdata !== 72'h0) begin fails++; $display("FAIL rst_mid_tdata: got %h required 0", dm.cmd_tdata); end
        @(posedge clk);
        #1 rst = 1'b0;
        dm.cmd_tready = 1'b1;
        tick();
        reg_read(O_STATUS, 1'b0, d);
        checks++; if (d !== 32'h0002_0000) begin fails++; $display("FAIL rst_mid_status: got %h required 00020000", d); end
        reg_read(O_CTRL, 1'b0, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL rst_mid_ctrl: got %h required 0", d); end
        reg_read(O_ADDR, 1'b0, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL rst_mid_addr: got %h required 0", d); end
        repeat (4) tick();
        checks++; if (got_q.size() != 0) begin fails++; $display("FAIL rst_mid_no_cmd: got %0d required 0", got_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_cmd();
        test_outstanding_limit();
        test_backpressure();
        test_overflow();
        test_status_pop();
        test_random();
        test_reset_mid_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
